// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces slide switches and KEY pushbuttons, with press pulse and sticky capture
module input_conditioner #(
    parameter int NUM_SW          = 10,
    parameter int NUM_KEY         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [NUM_SW-1:0]  sw_raw,
    input  logic [NUM_KEY-1:0] key_n_raw,
    input  logic [NUM_KEY-1:0] edge_clear,
    output logic [NUM_SW-1:0]  switches_export,
    output logic [NUM_KEY-1:0] pushbuttons_export,
    output logic [NUM_KEY-1:0] key_press_pulse,
    output logic [NUM_KEY-1:0] key_edge_capture
);
    // Switches and keys share one debounce datapath: keys occupy the upper bits.
    localparam int N = NUM_SW + NUM_KEY;
    // Keys idle released (1), switches idle low.
    localparam logic [N-1:0] RST_VAL = {{NUM_KEY{1'b1}}, {NUM_SW{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]       sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d;
    logic [CNT_W-1:0]   cnt_q [N];
    logic [CNT_W-1:0]   cnt_d [N];
    logic [NUM_KEY-1:0] pulse_q, pulse_d, capture_q, capture_d;

    // Synchronizer feed, per-bit debounce counters, press detection and sticky capture.
    always_comb begin
        sync1_d  = {key_n_raw, sw_raw};
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end
        end
        pulse_d   = stable_q[N-1:NUM_SW] & ~stable_d[N-1:NUM_SW];
        capture_d = pulse_q | (capture_q & ~edge_clear);
    end

    // State registers; asynchronous reset drops any partial debounce count.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q   <= RST_VAL;
            sync2_q   <= RST_VAL;
            stable_q  <= RST_VAL;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
            pulse_q   <= '0;
            capture_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
            pulse_q   <= pulse_d;
            capture_q <= capture_d;
        end
    end

    assign switches_export    = stable_q[NUM_SW-1:0];
    assign pushbuttons_export = stable_q[N-1:NUM_SW];
    assign key_press_pulse    = pulse_q;
    assign key_edge_capture   = capture_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench for input_conditioner with short debounce settings
module tb_input_conditioner;
    localparam int SW = 0, PB = 1, PU = 2, CAP = 3, PB1 = 4, PU1 = 5;

    typedef struct {
        int         cyc;
        int         sel;
        logic [9:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sw = 10'h3FF;
    logic [3:0] key = 4'hF, key1 = 4'hF, clr = 4'h0;
    logic [9:0] sw_exp, sw_exp1;
    logic [3:0] pb, pu, cap, pb1, pu1, cap1;
    int         cyc = 0;
    int         checks = 0, failures = 0;
    exp_t       sb[$];

    input_conditioner #(.NUM_SW(10), .NUM_KEY(4), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .sw_raw(sw), .key_n_raw(key), .edge_clear(clr),
        .switches_export(sw_exp), .pushbuttons_export(pb), .key_press_pulse(pu), .key_edge_capture(cap)
    );

    input_conditioner #(.NUM_SW(10), .NUM_KEY(4), .DEBOUNCE_CYCLES(1), .CNT_W(1)) dut1 (
        .clk_clk(clk), .reset_reset_n(rst_n), .sw_raw(10'h000), .key_n_raw(key1), .edge_clear(4'h0),
        .switches_export(sw_exp1), .pushbuttons_export(pb1), .key_press_pulse(pu1), .key_edge_capture(cap1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] actual_of(input int s);
        case (s)
            SW:      return sw_exp;
            PB:      return {6'h0, pb};
            PU:      return {6'h0, pu};
            CAP:     return {6'h0, cap};
            PB1:     return {6'h0, pb1};
            default: return {6'h0, pu1};
        endcase
    endfunction

    function automatic string name_of(input int s);
        case (s)
            SW:      return "switches_export";
            PB:      return "pushbuttons_export";
            PU:      return "key_press_pulse";
            CAP:     return "key_edge_capture";
            PB1:     return "pushbuttons_export(D=1)";
            default: return "key_press_pulse(D=1)";
        endcase
    endfunction

    // Monitor: every entry due this cycle is compared on the falling edge and retired.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                checks++;
                if (sb[i].cyc < cyc || actual_of(sb[i].sel) !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s cycle=%0d actual=%h expected=%h", name_of(sb[i].sel),
                             sb[i].cyc, actual_of(sb[i].sel), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic ex(input int off, input int s, input logic [9:0] v);
        exp_t e;
        e.cyc = cyc + off;
        e.sel = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held 3 cycles with switches high, keys released
        step(3);
        ex(0, SW, 10'h000); ex(0, PB, 10'hF); ex(0, PU, 10'h0); ex(0, CAP, 10'h0);
        ex(0, PB1, 10'hF); ex(0, PU1, 10'h0);
        rst_n = 1'b1;
        ex(1, SW, 10'h000); ex(5, SW, 10'h000); ex(6, SW, 10'h3FF);
        step(6);
        // Press key 2, then release it
        key = 4'hB;
        ex(5, PB, 10'hF); ex(6, PB, 10'hB);
        ex(5, PU, 10'h0); ex(6, PU, 10'h4); ex(7, PU, 10'h0);
        ex(6, CAP, 10'h0); ex(7, CAP, 10'h4); ex(11, CAP, 10'h4);
        step(11);
        key = 4'hF;
        ex(5, PB, 10'hB); ex(6, PB, 10'hF); ex(6, PU, 10'h0); ex(7, PU, 10'h0); ex(7, CAP, 10'h4);
        step(7);
        // Bring switch 0 low, then bounce it back high
        sw = 10'h3FE;
        ex(6, SW, 10'h3FE);
        step(6);
        sw = 10'h3FF;
        ex(3, SW, 10'h3FE); ex(6, SW, 10'h3FE); ex(9, SW, 10'h3FE); ex(10, SW, 10'h3FF);
        step(3);
        sw = 10'h3FE;
        step(1);
        sw = 10'h3FF;
        step(6);
        // Clear all captures, then two presses of key 0 with clear colliding with the second pulse
        clr = 4'hF;
        step(1);
        clr = 4'h0;
        ex(0, CAP, 10'h0);
        key = 4'hE;
        ex(6, PU, 10'h1); ex(7, CAP, 10'h1);
        step(7);
        key = 4'hF;
        step(6);
        key = 4'hE;
        ex(5, CAP, 10'h1); ex(6, PU, 10'h1); ex(6, CAP, 10'h1); ex(7, CAP, 10'h1);
        ex(8, CAP, 10'h1); ex(7, PU, 10'h0);
        step(6);
        clr = 4'h1;
        step(1);
        clr = 4'h0;
        key = 4'hF;
        step(1);
        clr = 4'h1;
        ex(0, CAP, 10'h1); ex(1, CAP, 10'h0);
        step(1);
        ex(1, CAP, 10'h0);
        step(1);
        clr = 4'h0;
        step(4);
        // Reset mid-count and mid-capture, then full-latency restart
        key = 4'h7;
        ex(6, PB, 10'h7); ex(6, PU, 10'h8); ex(7, CAP, 10'h8);
        step(7);
        sw = 10'h155;
        ex(3, SW, 10'h3FF); ex(3, CAP, 10'h8);
        step(4);
        #2;
        rst_n = 1'b0;
        ex(0, SW, 10'h000); ex(0, PB, 10'hF); ex(0, CAP, 10'h0); ex(0, PU, 10'h0);
        step(2);
        rst_n = 1'b1;
        ex(5, SW, 10'h000); ex(6, SW, 10'h155); ex(5, PB, 10'hF); ex(6, PB, 10'h7);
        ex(6, PU, 10'h8); ex(7, CAP, 10'h8);
        step(7);
        // Keys 0 and 3 together on the single-cycle debounce instance
        key1 = 4'h6;
        ex(2, PB1, 10'hF); ex(3, PB1, 10'h6); ex(2, PU1, 10'h0); ex(3, PU1, 10'h9); ex(4, PU1, 10'h0);
        step(6);
        for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
        if (sb.size() > 0) begin
            failures += sb.size();
            $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
